ps2_kbd_ctrl: RTL and testbench

Sequencing controller between the PS/2 byte receiver (FIFO-backed: data/ready/nextdata_n/overflow) and the keyboard display logic. It pops bytes from the receiver with a one-cycle nextdata_n strobe and parses the E0 (extended) and F0 (break) prefixes into make/break key events. It tracks the held key, counts key presses and flags protocol errors. The display/seven-segment logic consumes its outputs.

---
 rtl/ps2_kbd_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard sequencing controller: pops bytes from the receiver FIFO, parses
// E0/F0 prefixes into make/break events, tracks the held key and flags errors.
// Optional build macro PS2_REPEAT_FILTER_EN suppresses typematic-repeat make events.
module ps2_kbd_ctrl #(
  parameter int TIMEOUT_CYC = 50000,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       ps2_data,
  input  logic             ps2_ready,
  input  logic             ps2_overflow,
  output logic             ps2_nextdata_n,
  input  logic             err_clr,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_held,
  output logic             make_pulse,
  output logic             break_pulse,
  output logic [CNT_W-1:0] press_cnt,
  output logic             err_timeout,
  output logic             err_ovf
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  typedef enum logic {S_WAIT, S_POP} fsm_e;
  typedef enum logic [1:0] {C_NORM, C_EXT, C_BRK} ctx_e;

  fsm_e             fsm_q, fsm_d;
  ctx_e             ctx_q, ctx_d;
  logic             brk_ext_q, brk_ext_d;
  logic [7:0]       byte_q, byte_d;
  logic             nextdata_n_q, nextdata_n_d;
  logic [7:0]       key_code_q, key_code_d;
  logic             key_ext_q, key_ext_d;
  logic             key_held_q, key_held_d;
  logic             make_pulse_q, make_pulse_d;
  logic             break_pulse_q, break_pulse_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic             err_timeout_q, err_timeout_d;
  logic             err_ovf_q, err_ovf_d;
  logic [TW-1:0]    timer_q, timer_d;

  ctx_e ctx_cur;
  logic do_make, make_ext, count_make, timeout_hit;

  // NOTE: every combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    fsm_d         = fsm_q;
    brk_ext_d     = brk_ext_q;
    byte_d        = byte_q;
    nextdata_n_d  = 1'b1;
    key_code_d    = key_code_q;
    key_ext_d     = key_ext_q;
    key_held_d    = key_held_q;
    make_pulse_d  = 1'b0;
    break_pulse_d = 1'b0;
    press_cnt_d   = press_cnt_q;
    timer_d       = '0;
    do_make       = 1'b0;
    make_ext      = 1'b0;
    count_make    = 1'b1;
    timeout_hit   = 1'b0;

    // An overflow abandons any partial prefix, including one about to be decoded.
    ctx_cur = ps2_overflow ? C_NORM : ctx_q;
    ctx_d   = ctx_cur;

    case (fsm_q)
      S_WAIT: begin
        if (ps2_ready) begin
          byte_d       = ps2_data;
          nextdata_n_d = 1'b0;
          fsm_d        = S_POP;
        end else if (ctx_cur != C_NORM) begin
          if (timer_q == TIMER_LAST) begin
            timeout_hit = 1'b1;
            ctx_d       = C_NORM;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      S_POP: begin
        fsm_d = S_WAIT;
        case (ctx_cur)
          C_NORM: begin
            if (byte_q == PFX_EXT) begin
              ctx_d = C_EXT;
            end else if (byte_q == PFX_BRK) begin
              ctx_d     = C_BRK;
              brk_ext_d = 1'b0;
            end else begin
              do_make = 1'b1;
            end
          end
          C_EXT: begin
            if (byte_q == PFX_BRK) begin
              ctx_d     = C_BRK;
              brk_ext_d = 1'b1;
            end else if (byte_q != PFX_EXT) begin
              do_make  = 1'b1;
              make_ext = 1'b1;
              ctx_d    = C_NORM;
            end
          end
          default: begin
            ctx_d = C_NORM;
            if (byte_q != PFX_EXT && byte_q != PFX_BRK) begin
              break_pulse_d = 1'b1;
              if (byte_q == key_code_q && brk_ext_q == key_ext_q) key_held_d = 1'b0;
            end
          end
        endcase
      end
      default: fsm_d = S_WAIT;
    endcase

`ifdef PS2_REPEAT_FILTER_EN
    count_make = !(key_held_q && byte_q == key_code_q && make_ext == key_ext_q);
`endif

    if (do_make) begin
      key_code_d = byte_q;
      key_ext_d  = make_ext;
      key_held_d = 1'b1;
      if (count_make) begin
        make_pulse_d = 1'b1;
        press_cnt_d  = press_cnt_q + CNT_W'(1);
      end
    end

    // A fresh error in the same cycle as err_clr keeps its flag set.
    err_timeout_d = (err_timeout_q & ~err_clr) | timeout_hit;
    err_ovf_d     = (err_ovf_q & ~err_clr) | ps2_overflow;
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q         <= S_WAIT;
      ctx_q         <= C_NORM;
      brk_ext_q     <= 1'b0;
      byte_q        <= '0;
      nextdata_n_q  <= 1'b1;
      key_code_q    <= '0;
      key_ext_q     <= 1'b0;
      key_held_q    <= 1'b0;
      make_pulse_q  <= 1'b0;
      break_pulse_q <= 1'b0;
      press_cnt_q   <= '0;
      err_timeout_q <= 1'b0;
      err_ovf_q     <= 1'b0;
      timer_q       <= '0;
    end else begin
      fsm_q         <= fsm_d;
      ctx_q         <= ctx_d;
      brk_ext_q     <= brk_ext_d;
      byte_q        <= byte_d;
      nextdata_n_q  <= nextdata_n_d;
      key_code_q    <= key_code_d;
      key_ext_q     <= key_ext_d;
      key_held_q    <= key_held_d;
      make_pulse_q  <= make_pulse_d;
      break_pulse_q <= break_pulse_d;
      press_cnt_q   <= press_cnt_d;
      err_timeout_q <= err_timeout_d;
      err_ovf_q     <= err_ovf_d;
      timer_q       <= timer_d;
    end
  end

  assign ps2_nextdata_n = nextdata_n_q;
  assign key_code       = key_code_q;
  assign key_ext        = key_ext_q;
  assign key_held       = key_held_q;
  assign make_pulse     = make_pulse_q;
  assign break_pulse    = break_pulse_q;
  assign press_cnt      = press_cnt_q;
  assign err_timeout    = err_timeout_q;
  assign err_ovf        = err_ovf_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench for ps2_kbd_ctrl: the bench plays the receiver FIFO and keeps
// a prefix-flag model of the key parser; directed scenarios plus randomized traffic.
module tb_ps2_kbd_ctrl;
  localparam int TO = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    ps2_data = '0;
  logic          ps2_ready = 1'b0;
  logic          ps2_overflow = 1'b0;
  logic          err_clr = 1'b0;
  logic          ps2_nextdata_n;
  logic [7:0]    key_code;
  logic          key_ext, key_held, make_pulse, break_pulse;
  logic [CW-1:0] press_cnt;
  logic          err_timeout, err_ovf;

  ps2_kbd_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
    .ps2_overflow(ps2_overflow), .ps2_nextdata_n(ps2_nextdata_n), .err_clr(err_clr),
    .key_code(key_code), .key_ext(key_ext), .key_held(key_held),
    .make_pulse(make_pulse), .break_pulse(break_pulse), .press_cnt(press_cnt),
    .err_timeout(err_timeout), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int n_mk_seen, n_bk_seen, n_pop_seen;

  // Receiver FIFO contents and the model's view of the parser.
  logic [7:0] fifo[$];
  bit         m_pending, m_ext, m_brk, m_kext, m_held, m_mk, m_bk, m_eto, m_eovf;
  logic [7:0] m_code;
  logic [CW-1:0] m_cnt;
  int         m_idle;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_pending = 0; m_ext = 0; m_brk = 0; m_kext = 0; m_held = 0;
    m_mk = 0; m_bk = 0; m_eto = 0; m_eovf = 0; m_code = '0; m_cnt = '0; m_idle = 0;
  endtask

  // Apply one received byte to the prefix flags and key state.
  task automatic consume(input logic [7:0] b);
    bit rep;
    if (m_brk) begin
      if (b != 8'hE0 && b != 8'hF0) begin
        m_bk = 1;
        if (b == m_code && m_ext == m_kext) m_held = 0;
      end
      m_brk = 0; m_ext = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      rep = m_held && b == m_code && m_ext == m_kext;
`ifdef PS2_REPEAT_FILTER_EN
      if (!rep) begin m_mk = 1; m_cnt = m_cnt + 1'b1; end
`else
      m_mk = 1; m_cnt = m_cnt + 1'b1;
      if (rep) m_mk = 1;
`endif
      m_code = b; m_kext = m_ext; m_held = 1; m_ext = 0;
    end
  endtask

  // What one rising edge does, given the inputs presented to it.
  task automatic model_edge(input bit rdy, input bit ovf, input bit clr);
    bit to_new = 0;
    m_mk = 0; m_bk = 0;
    if (ovf) begin m_ext = 0; m_brk = 0; end
    if (m_pending) begin
      consume(fifo.pop_front());
      m_idle = 0;
    end else if (rdy) begin
      m_idle = 0;
    end else if (m_ext || m_brk) begin
      m_idle++;
      if (m_idle == TO) begin m_ext = 0; m_brk = 0; to_new = 1; m_idle = 0; end
    end else begin
      m_idle = 0;
    end
    m_eto  = (m_eto && !clr) || to_new;
    m_eovf = (m_eovf && !clr) || ovf;
    m_pending = !m_pending && rdy;
  endtask

  task automatic compare_all();
    check("nextdata_n", ps2_nextdata_n, !m_pending);
    check("key_code", key_code, m_code);
    check("key_ext", key_ext, m_kext);
    check("key_held", key_held, m_held);
    check("make_pulse", make_pulse, m_mk);
    check("break_pulse", break_pulse, m_bk);
    check("press_cnt", press_cnt, m_cnt);
    check("err_timeout", err_timeout, m_eto);
    check("err_ovf", err_ovf, m_eovf);
    if (make_pulse) n_mk_seen++;
    if (break_pulse) n_bk_seen++;
    if (!ps2_nextdata_n) n_pop_seen++;
  endtask

  // Called at a falling edge: check, drive the next edge's inputs, advance the model.
  task automatic step(input bit ovf, input bit clr, input bit gap);
    bit rdy;
    compare_all();
    rdy = fifo.size() > 0 && !gap;
    ps2_ready    = rdy;
    ps2_data     = (fifo.size() > 0) ? fifo[0] : 8'($urandom);
    ps2_overflow = ovf;
    err_clr      = clr;
    model_edge(rdy, ovf, clr);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int guard = 0;
    while ((fifo.size() > 0 || m_pending) && guard < 2000) begin
      step(0, 0, 0);
      guard++;
    end
    check("drain_bound", guard < 2000, 1);
    step(0, 0, 0);
    step(0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ps2_ready = 0; ps2_overflow = 0; err_clr = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_reset();
    n_mk_seen = 0; n_bk_seen = 0; n_pop_seen = 0;
  endtask

  task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    fifo.push_back(a); fifo.push_back(b); fifo.push_back(c);
  endtask

  initial begin
    m_reset();
    n_mk_seen = 0; n_bk_seen = 0; n_pop_seen = 0;
    repeat (3) @(negedge clk);
    check("rst_nextdata_n", ps2_nextdata_n, 1);
    check("rst_press_cnt", press_cnt, 0);
    rst = 1'b1;

    // Make 1C, then break it, with the data continuously ready.
    push3(8'h1C, 8'hF0, 8'h1C);
    drain();
    check("t1_makes", n_mk_seen, 1);
    check("t1_breaks", n_bk_seen, 1);
    check("t1_pops", n_pop_seen, 3);
    check("t1_code", key_code, 8'h1C);
    check("t1_held", key_held, 0);
    check("t1_cnt", press_cnt, 1);

    // Extended make and break of E0 75.
    do_reset();
    push3(8'hE0, 8'h75, 8'hE0);
    fifo.push_back(8'hF0); fifo.push_back(8'h75);
    drain();
    check("t2_code", key_code, 8'h75);
    check("t2_ext", key_ext, 1);
    check("t2_held", key_held, 0);
    check("t2_cnt", press_cnt, 1);

    // Break prefix left dangling long enough to time out.
    do_reset();
    fifo.push_back(8'hF0);
    drain();
    repeat (TO) step(0, 0, 0);
    check("t3_err_timeout", err_timeout, 1);
    fifo.push_back(8'h1C);
    drain();
    check("t3_code", key_code, 8'h1C);
    check("t3_held", key_held, 1);
    check("t3_cnt", press_cnt, 1);
    step(0, 1, 0);
    step(0, 0, 0);
    check("t3_err_cleared", err_timeout, 0);

    // Typematic repeat.
    do_reset();
    push3(8'h1C, 8'h1C, 8'h1C);
    drain();
`ifdef PS2_REPEAT_FILTER_EN
    check("t4_makes", n_mk_seen, 1);
    check("t4_cnt", press_cnt, 1);
`else
    check("t4_makes", n_mk_seen, 3);
    check("t4_cnt", press_cnt, 3);
`endif

    // Counter wrap, then overflow discarding an E0 prefix.
    do_reset();
    for (int i = 0; i < 256; i++) fifo.push_back((i % 2 == 0) ? 8'h1C : 8'h1D);
    drain();
    check("t5_makes", n_mk_seen, 256);
    check("t5_wrap", press_cnt, 0);
    fifo.push_back(8'hE0);
    drain();
    step(1, 0, 0);
    fifo.push_back(8'h29);
    drain();
    check("t5_err_ovf", err_ovf, 1);
    check("t5_code", key_code, 8'h29);
    check("t5_ext", key_ext, 0);
    check("t5_cnt", press_cnt, 1);

    // Asynchronous reset while a pop is in flight.
    fifo.push_back(8'h33);
    step(0, 0, 0);
    check("t6_in_pop", ps2_nextdata_n, 0);
    #2 rst = 1'b0;
    #1;
    check("t6_nextdata_n", ps2_nextdata_n, 1);
    check("t6_code", key_code, 0);
    check("t6_held", key_held, 0);
    check("t6_cnt", press_cnt, 0);
    check("t6_err_ovf", err_ovf, 0);
    @(negedge clk);
    rst = 1'b1;
    m_reset();
    drain();

    // Randomized traffic with gaps, overflows, clears and idle stretches.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int r = $urandom_range(0, 99);
      if (cyc % 400 >= 370) begin
        step(0, 0, 1);
      end else begin
        if (fifo.size() < 4 && $urandom_range(0, 2) == 0) begin
          int k = $urandom_range(0, 9);
          logic [7:0] set4[4] = '{8'h1C, 8'h1D, 8'h75, 8'h29};
          if (k < 2) fifo.push_back(8'hE0);
          else if (k < 4) fifo.push_back(8'hF0);
          else if (k < 9) fifo.push_back(set4[$urandom_range(0, 3)]);
          else fifo.push_back(8'($urandom));
        end
        step(r < 2, r >= 96, $urandom_range(0, 3) == 0);
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
